// File: rtl/i2c_target_if.sv
// Application-side view of the I2C target: read-back bytes in, received bytes
// and bus status out.
`timescale 1ns/1ps
interface i2c_target_if #(
  parameter int DATA_LEN = 8
);
  logic [DATA_LEN-1:0] tx_data_0;
  logic [DATA_LEN-1:0] tx_data_1;
  logic [DATA_LEN-1:0] rx_data_0;
  logic [DATA_LEN-1:0] rx_data_1;
  logic                rx_valid;
  logic                rx_index;
  logic                addr_match;
  logic                busy;
  logic [3:0]          state_target;

  modport master (
    output tx_data_0, tx_data_1,
    input  rx_data_0, rx_data_1, rx_valid, rx_index, addr_match, busy, state_target
  );

  modport slave (
    input  tx_data_0, tx_data_1,
    output rx_data_0, rx_data_1, rx_valid, rx_index, addr_match, busy, state_target
  );
endinterface

// File: rtl/i2c_target_fsm.sv
// Oversampled I2C target: START/STOP detect, 7-bit address match, write/read of
// up to MAX_BYTES bytes. Define GENERAL_CALL_EN to also ACK writes to 7'h00.
`timescale 1ns/1ps
module i2c_target_fsm #(
  parameter int                  ADDR_LEN    = 7,
  parameter int                  DATA_LEN    = 8,
  parameter logic [ADDR_LEN-1:0] TARGET_ADDR = 7'h52,
  parameter int                  MAX_BYTES   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        scl,
  inout  wire         sda,
  i2c_target_if.slave tgt
);

`ifdef GENERAL_CALL_EN
  localparam logic GC_EN = 1'b1;
`else
  localparam logic GC_EN = 1'b0;
`endif

  localparam int                CNT_W    = $clog2(MAX_BYTES + 1);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_BYTES);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BYTES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [3:0]       BITS     = 4'(DATA_LEN);

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ADDR      = 4'd1,
    ST_ADDR_ACK  = 4'd2,
    ST_RX_DATA   = 4'd3,
    ST_RX_ACK    = 4'd4,
    ST_RX_NACK   = 4'd5,
    ST_TX_DATA   = 4'd6,
    ST_TX_ACK    = 4'd7,
    ST_WAIT_STOP = 4'd8
  } state_t;

  function automatic logic addr_ok(input logic [ADDR_LEN-1:0] addr, input logic rw);
    return (addr == TARGET_ADDR) || (GC_EN && (addr == {ADDR_LEN{1'b0}}) && !rw);
  endfunction

  logic [1:0]          scl_sync_r, sda_sync_r;
  logic                scl_prev_r, sda_prev_r;
  state_t              state_r;
  logic [3:0]          bit_cnt_r;
  logic [CNT_W-1:0]    byte_cnt_r;
  logic [DATA_LEN-1:0] shreg_r, tx_shreg_r, rx_data_0_r, rx_data_1_r;
  logic                rw_r, sda_oe_r, rx_valid_r, rx_index_r, addr_match_r, busy_r;

  logic scl_s, sda_s, scl_rise_s, scl_fall_s, start_s, stop_s;
  assign scl_s      = scl_sync_r[1];
  assign sda_s      = sda_sync_r[1];
  assign scl_rise_s = scl_s & ~scl_prev_r;
  assign scl_fall_s = ~scl_s & scl_prev_r;
  assign start_s    = scl_s & scl_prev_r & ~sda_s & sda_prev_r;
  assign stop_s     = scl_s & scl_prev_r & sda_s & ~sda_prev_r;

  assign sda              = sda_oe_r ? 1'b0 : 1'bz;
  assign tgt.rx_data_0    = rx_data_0_r;
  assign tgt.rx_data_1    = rx_data_1_r;
  assign tgt.rx_valid     = rx_valid_r;
  assign tgt.rx_index     = rx_index_r;
  assign tgt.addr_match   = addr_match_r;
  assign tgt.busy         = busy_r;
  assign tgt.state_target = state_r;

  // Two-flop synchronisers plus a history flop for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_r <= 2'b11;
      sda_sync_r <= 2'b11;
      scl_prev_r <= 1'b1;
      sda_prev_r <= 1'b1;
    end else begin
      scl_sync_r <= {scl_sync_r[0], scl};
      sda_sync_r <= {sda_sync_r[0], sda};
      scl_prev_r <= scl_sync_r[1];
      sda_prev_r <= sda_sync_r[1];
    end
  end

  // Protocol FSM; START/STOP override any scl edge seen in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      bit_cnt_r    <= 4'd0;
      byte_cnt_r   <= {CNT_W{1'b0}};
      shreg_r      <= {DATA_LEN{1'b0}};
      tx_shreg_r   <= {DATA_LEN{1'b0}};
      rx_data_0_r  <= {DATA_LEN{1'b0}};
      rx_data_1_r  <= {DATA_LEN{1'b0}};
      rw_r         <= 1'b0;
      sda_oe_r     <= 1'b0;
      rx_valid_r   <= 1'b0;
      rx_index_r   <= 1'b0;
      addr_match_r <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      rx_valid_r <= 1'b0;
      if (start_s) begin
        state_r      <= ST_ADDR;
        bit_cnt_r    <= 4'd0;
        byte_cnt_r   <= {CNT_W{1'b0}};
        sda_oe_r     <= 1'b0;
        addr_match_r <= 1'b0;
        busy_r       <= 1'b1;
      end else if (stop_s) begin
        state_r      <= ST_IDLE;
        sda_oe_r     <= 1'b0;
        addr_match_r <= 1'b0;
        busy_r       <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE: sda_oe_r <= 1'b0;
          ST_ADDR: begin
            if (scl_rise_s && (bit_cnt_r < BITS)) begin
              shreg_r   <= {shreg_r[DATA_LEN-2:0], sda_s};
              bit_cnt_r <= bit_cnt_r + 4'd1;
            end else if (scl_fall_s && (bit_cnt_r == BITS)) begin
              state_r      <= ST_ADDR_ACK;
              rw_r         <= shreg_r[0];
              sda_oe_r     <= addr_ok(shreg_r[ADDR_LEN:1], shreg_r[0]);
              addr_match_r <= addr_ok(shreg_r[ADDR_LEN:1], shreg_r[0]);
            end
          end
          ST_ADDR_ACK: begin
            if (!addr_match_r) begin
              state_r  <= ST_WAIT_STOP;
              sda_oe_r <= 1'b0;
            end else if (scl_fall_s) begin
              // The fall ending the ACK already carries the first read bit.
              if (rw_r) begin
                state_r    <= ST_TX_DATA;
                sda_oe_r   <= ~tgt.tx_data_0[DATA_LEN-1];
                tx_shreg_r <= {tgt.tx_data_0[DATA_LEN-2:0], 1'b0};
                bit_cnt_r  <= 4'd1;
              end else begin
                state_r   <= ST_RX_DATA;
                sda_oe_r  <= 1'b0;
                bit_cnt_r <= 4'd0;
              end
            end
          end
          ST_RX_DATA: begin
            if (scl_rise_s) begin
              shreg_r <= {shreg_r[DATA_LEN-2:0], sda_s};
              if (bit_cnt_r == (BITS - 4'd1)) begin
                bit_cnt_r <= 4'd0;
                if (byte_cnt_r < MAX_CNT) begin
                  if (byte_cnt_r[0]) rx_data_1_r <= {shreg_r[DATA_LEN-2:0], sda_s};
                  else               rx_data_0_r <= {shreg_r[DATA_LEN-2:0], sda_s};
                  rx_valid_r <= 1'b1;
                  rx_index_r <= byte_cnt_r[0];
                  state_r    <= ST_RX_ACK;
                end else begin
                  state_r <= ST_RX_NACK;
                end
              end else begin
                bit_cnt_r <= bit_cnt_r + 4'd1;
              end
            end
          end
          ST_RX_ACK: begin
            // bit_cnt marks whether the ACK low phase has started.
            if (scl_fall_s) begin
              if (bit_cnt_r == 4'd0) begin
                sda_oe_r  <= 1'b1;
                bit_cnt_r <= 4'd1;
              end else begin
                sda_oe_r   <= 1'b0;
                bit_cnt_r  <= 4'd0;
                byte_cnt_r <= byte_cnt_r + CNT_ONE;
                state_r    <= ST_RX_DATA;
              end
            end
          end
          ST_RX_NACK: begin
            sda_oe_r <= 1'b0;
            if (scl_fall_s) begin
              if (bit_cnt_r == 4'd0) bit_cnt_r <= 4'd1;
              else                   state_r   <= ST_WAIT_STOP;
            end
          end
          ST_TX_DATA: begin
            if (scl_fall_s) begin
              if (bit_cnt_r == BITS) begin
                sda_oe_r <= 1'b0;
                state_r  <= ST_TX_ACK;
              end else begin
                sda_oe_r   <= ~tx_shreg_r[DATA_LEN-1];
                tx_shreg_r <= {tx_shreg_r[DATA_LEN-2:0], 1'b0};
                bit_cnt_r  <= bit_cnt_r + 4'd1;
              end
            end
          end
          ST_TX_ACK: begin
            if (scl_rise_s) begin
              if (!sda_s && (byte_cnt_r < LAST_CNT)) begin
                byte_cnt_r <= byte_cnt_r + CNT_ONE;
                // Next byte index is byte_cnt+1, so an even count selects tx_data_1.
                tx_shreg_r <= byte_cnt_r[0] ? tgt.tx_data_0 : tgt.tx_data_1;
                bit_cnt_r  <= 4'd0;
                state_r    <= ST_TX_DATA;
              end else begin
                state_r <= ST_WAIT_STOP;
              end
            end
          end
          ST_WAIT_STOP: sda_oe_r <= 1'b0;
          default: begin
            state_r  <= ST_IDLE;
            sda_oe_r <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_i2c_target_fsm.sv
// Directed bench: bit-banged bus master against i2c_target_fsm with hand-computed expectations.
`timescale 1ns/1ps
module tb_i2c_target_fsm;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic scl_m = 1'b1;
  logic m_low = 1'b0;
  wire  sda_net;
  int   n_checks = 0;
  int   n_fail = 0;
  int   rxv_cnt = 0;
  int   drive_cnt = 0;
  logic rxv_idx [0:15];

  assign sda_net = m_low ? 1'b0 : 1'bz;
  pullup (sda_net);

  always #5 clk = ~clk;

  i2c_target_if #(.DATA_LEN(8)) bus_if ();

  i2c_target_fsm dut (
    .clk   (clk),
    .rst_n (rst_n),
    .scl   (scl_m),
    .sda   (sda_net),
    .tgt   (bus_if.slave)
  );

  // Log rx_valid pulses and any low level on sda the master is not causing.
  always @(negedge clk) begin
    if (bus_if.rx_valid) begin
      if (rxv_cnt < 16) rxv_idx[rxv_cnt] <= bus_if.rx_index;
      rxv_cnt <= rxv_cnt + 1;
    end
    if (sda_net === 1'b0 && !m_low) drive_cnt <= drive_cnt + 1;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic write_bit(input logic b);
    m_low = ~b; wait_clk(5);
    scl_m = 1'b1; wait_clk(10);
    scl_m = 1'b0; wait_clk(5);
  endtask

  task automatic read_bit(output logic b);
    m_low = 1'b0; wait_clk(5);
    scl_m = 1'b1; wait_clk(5);
    b = sda_net; wait_clk(5);
    scl_m = 1'b0; wait_clk(5);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(input logic ack, output logic [7:0] d);
    for (int i = 7; i >= 0; i--) read_bit(d[i]);
    write_bit(ack);
  endtask

  task automatic i2c_start();
    m_low = 1'b0; wait_clk(5);
    scl_m = 1'b1; wait_clk(10);
    m_low = 1'b1; wait_clk(10);
    scl_m = 1'b0; wait_clk(5);
  endtask

  task automatic i2c_stop();
    m_low = 1'b1; wait_clk(5);
    scl_m = 1'b1; wait_clk(10);
    m_low = 1'b0; wait_clk(10);
  endtask

  task automatic test_reset();
    wait_clk(3);
    n_checks++; if (bus_if.state_target !== 4'd0) begin n_fail++; $display("FAIL reset_state got=%0d exp=0", bus_if.state_target); end
    n_checks++; if (bus_if.rx_data_0 !== 8'h00 || bus_if.rx_data_1 !== 8'h00) begin n_fail++; $display("FAIL reset_rx got=%h/%h exp=00/00", bus_if.rx_data_0, bus_if.rx_data_1); end
    n_checks++; if ({bus_if.rx_valid, bus_if.rx_index, bus_if.addr_match, bus_if.busy} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags got=%b exp=0000", {bus_if.rx_valid, bus_if.rx_index, bus_if.addr_match, bus_if.busy}); end
    n_checks++; if (sda_net !== 1'b1) begin n_fail++; $display("FAIL reset_sda got=%b exp=1", sda_net); end
    rst_n = 1'b1;
    wait_clk(5);
  endtask

  task automatic test_write();
    logic ack;
    int   c0;
    c0 = rxv_cnt;
    i2c_start();
    n_checks++; if (bus_if.busy !== 1'b1) begin n_fail++; $display("FAIL wr_busy got=%b exp=1", bus_if.busy); end
    write_byte(8'hA4, ack);
    n_checks++; if (ack !== 1'b0) begin n_fail++; $display("FAIL wr_addr_ack got=%b exp=0", ack); end
    n_checks++; if (bus_if.addr_match !== 1'b1 || bus_if.state_target !== 4'd3) begin n_fail++; $display("FAIL wr_match got=%b/%0d exp=1/3", bus_if.addr_match, bus_if.state_target); end
    write_byte(8'hA5, ack);
    n_checks++; if (ack !== 1'b0) begin n_fail++; $display("FAIL wr_b0_ack got=%b exp=0", ack); end
    write_byte(8'h3C, ack);
    n_checks++; if (ack !== 1'b0) begin n_fail++; $display("FAIL wr_b1_ack got=%b exp=0", ack); end
    i2c_stop();
    n_checks++; if (bus_if.rx_data_0 !== 8'hA5 || bus_if.rx_data_1 !== 8'h3C) begin n_fail++; $display("FAIL wr_data got=%h/%h exp=a5/3c", bus_if.rx_data_0, bus_if.rx_data_1); end
    n_checks++; if (rxv_cnt - c0 !== 2) begin n_fail++; $display("FAIL wr_pulses got=%0d exp=2", rxv_cnt - c0); end
    n_checks++; if (rxv_idx[c0] !== 1'b0 || rxv_idx[c0+1] !== 1'b1) begin n_fail++; $display("FAIL wr_index got=%b%b exp=01", rxv_idx[c0], rxv_idx[c0+1]); end
    n_checks++; if (bus_if.state_target !== 4'd0 || bus_if.busy !== 1'b0 || bus_if.addr_match !== 1'b0) begin n_fail++; $display("FAIL wr_end got=%0d/%b/%b exp=0/0/0", bus_if.state_target, bus_if.busy, bus_if.addr_match); end
  endtask

  task automatic test_mismatch();
    logic ack;
    int   c0, d0;
    c0 = rxv_cnt; d0 = drive_cnt;
    i2c_start();
    write_byte(8'h26, ack);
    n_checks++; if (ack !== 1'b1) begin n_fail++; $display("FAIL mm_addr_ack got=%b exp=1", ack); end
    write_byte(8'h55, ack);
    n_checks++; if (bus_if.state_target !== 4'd8 || bus_if.addr_match !== 1'b0) begin n_fail++; $display("FAIL mm_state got=%0d/%b exp=8/0", bus_if.state_target, bus_if.addr_match); end
    i2c_stop();
    n_checks++; if (bus_if.state_target !== 4'd0) begin n_fail++; $display("FAIL mm_idle got=%0d exp=0", bus_if.state_target); end
    n_checks++; if (rxv_cnt !== c0 || drive_cnt !== d0) begin n_fail++; $display("FAIL mm_quiet got=%0d/%0d exp=%0d/%0d", rxv_cnt, drive_cnt, c0, d0); end
  endtask

  task automatic test_read();
    logic       ack;
    logic [7:0] d;
    i2c_start();
    write_byte(8'hA5, ack);
    n_checks++; if (ack !== 1'b0) begin n_fail++; $display("FAIL rd_addr_ack got=%b exp=0", ack); end
    read_byte(1'b0, d);
    n_checks++; if (d !== 8'hC3) begin n_fail++; $display("FAIL rd_byte0 got=%h exp=c3", d); end
    read_byte(1'b1, d);
    n_checks++; if (d !== 8'h5A) begin n_fail++; $display("FAIL rd_byte1 got=%h exp=5a", d); end
    wait_clk(4);
    n_checks++; if (bus_if.state_target !== 4'd8 || sda_net !== 1'b1) begin n_fail++; $display("FAIL rd_release got=%0d/%b exp=8/1", bus_if.state_target, sda_net); end
    i2c_stop();
  endtask

  task automatic test_overflow();
    logic ack;
    int   c0;
    c0 = rxv_cnt;
    i2c_start();
    write_byte(8'hA4, ack);
    write_byte(8'h11, ack);
    n_checks++; if (ack !== 1'b0) begin n_fail++; $display("FAIL ov_b0_ack got=%b exp=0", ack); end
    write_byte(8'h22, ack);
    n_checks++; if (ack !== 1'b0) begin n_fail++; $display("FAIL ov_b1_ack got=%b exp=0", ack); end
    write_byte(8'h33, ack);
    n_checks++; if (ack !== 1'b1) begin n_fail++; $display("FAIL ov_b2_nack got=%b exp=1", ack); end
    i2c_stop();
    n_checks++; if (bus_if.rx_data_0 !== 8'h11 || bus_if.rx_data_1 !== 8'h22) begin n_fail++; $display("FAIL ov_data got=%h/%h exp=11/22", bus_if.rx_data_0, bus_if.rx_data_1); end
    n_checks++; if (rxv_cnt - c0 !== 2) begin n_fail++; $display("FAIL ov_pulses got=%0d exp=2", rxv_cnt - c0); end
  endtask

  task automatic test_back_to_back();
    logic       ack;
    logic [7:0] d;
    i2c_start();
    write_byte(8'hA4, ack);
    write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b0);
    i2c_start();
    n_checks++; if (bus_if.state_target !== 4'd1) begin n_fail++; $display("FAIL rs_addr got=%0d exp=1", bus_if.state_target); end
    write_byte(8'hA5, ack);
    n_checks++; if (ack !== 1'b0) begin n_fail++; $display("FAIL rs_addr_ack got=%b exp=0", ack); end
    read_byte(1'b1, d);
    n_checks++; if (d !== 8'hC3) begin n_fail++; $display("FAIL rs_byte got=%h exp=c3", d); end
    i2c_stop();
    n_checks++; if (bus_if.state_target !== 4'd0) begin n_fail++; $display("FAIL rs_idle got=%0d exp=0", bus_if.state_target); end
  endtask

  task automatic test_reset_mid_ack();
    logic ack;
    int   d0;
    i2c_start();
    for (int i = 7; i >= 0; i--) write_bit(logic'((8'hA4 >> i) & 8'h01));
    m_low = 1'b0;
    wait_clk(1);
    n_checks++; if (sda_net !== 1'b0) begin n_fail++; $display("FAIL rst_ack_driven got=%b exp=0", sda_net); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (sda_net !== 1'b1 || bus_if.state_target !== 4'd0) begin n_fail++; $display("FAIL rst_release got=%b/%0d exp=1/0", sda_net, bus_if.state_target); end
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(2);
    d0 = drive_cnt;
    write_byte(8'hA4, ack);
    n_checks++; if (ack !== 1'b1 || drive_cnt !== d0) begin n_fail++; $display("FAIL rst_no_rearm got=%b/%0d exp=1/%0d", ack, drive_cnt, d0); end
    n_checks++; if (bus_if.state_target !== 4'd0 || bus_if.rx_data_0 !== 8'h00 || bus_if.busy !== 1'b0) begin n_fail++; $display("FAIL rst_state got=%0d/%h/%b exp=0/00/0", bus_if.state_target, bus_if.rx_data_0, bus_if.busy); end
    i2c_stop();
  endtask

  task automatic test_general_call();
    logic ack;
    i2c_start();
    write_byte(8'h01, ack);
    n_checks++; if (ack !== 1'b1) begin n_fail++; $display("FAIL gc_read_nack got=%b exp=1", ack); end
    i2c_stop();
    i2c_start();
    write_byte(8'h00, ack);
`ifdef GENERAL_CALL_EN
    n_checks++; if (ack !== 1'b0 || bus_if.addr_match !== 1'b1) begin n_fail++; $display("FAIL gc_addr got=%b/%b exp=0/1", ack, bus_if.addr_match); end
    write_byte(8'h77, ack);
    n_checks++; if (ack !== 1'b0 || bus_if.rx_data_0 !== 8'h77) begin n_fail++; $display("FAIL gc_data got=%b/%h exp=0/77", ack, bus_if.rx_data_0); end
`else
    n_checks++; if (ack !== 1'b1 || bus_if.addr_match !== 1'b0) begin n_fail++; $display("FAIL gc_addr got=%b/%b exp=1/0", ack, bus_if.addr_match); end
    write_byte(8'h77, ack);
    n_checks++; if (ack !== 1'b1 || bus_if.rx_data_0 !== 8'h00) begin n_fail++; $display("FAIL gc_data got=%b/%h exp=1/00", ack, bus_if.rx_data_0); end
`endif
    i2c_stop();
  endtask

  initial begin
    bus_if.tx_data_0 = 8'hC3;
    bus_if.tx_data_1 = 8'h5A;
    test_reset();
    test_write();
    test_mismatch();
    test_read();
    test_overflow();
    test_back_to_back();
    test_reset_mid_ack();
    test_general_call();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
